// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store engine driving a simple request/ack memory port.
// An aligned access in IDLE is captured once. It is held on the memory port with mem_req high
// until mem_ack arrives or ACK_TIMEOUT cycles pass. The unit then spends one RESP cycle
// reporting the result. Byte lanes are big-endian: byte offset 0 is mem_rdata[31:24].
//
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   MemWriteM, MemToRegM       store / load request (store wins when both are high)
//   MaskOp, LoadSignM          access size (00 word, 01 byte, 10 half, 11 word), sign-extend
//   AddrM, WriteDataM          byte address, right-justified store data
//   StallM, MisalignM          pipeline freeze, combinational misalignment flag
//   ReadValidW, ReadDataW      load-result pulse and extended load data
//   ErrorM                     one-cycle pulse on ack timeout
//   mem_req .. mem_rdata       memory request/ack interface
module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWriteM,
  input  logic        MemToRegM,
  input  logic [1:0]  MaskOp,
  input  logic        LoadSignM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        ReadValidW,
  output logic [31:0] ReadDataW,
  output logic        ErrorM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q;
  logic            we_q, load_q, sign_q, byte_q, half_q;
  logic [1:0]      off_q;
  logic [3:0]      be_q;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic            rvalid_q, err_q;

  logic        access, is_byte, is_half, is_word, misalign, start, ack_hit, timeout;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_ext;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign access   = MemWriteM | MemToRegM;
  assign is_byte  = (MaskOp == 2'b01);
  assign is_half  = (MaskOp == 2'b10);
  assign is_word  = ~is_byte & ~is_half;
  assign misalign = access & ((is_word & (AddrM[1:0] != 2'b00)) | (is_half & AddrM[0]));
  assign start    = (state_q == StIdle) & access & ~misalign;
  assign ack_hit  = (state_q == StAccess) & mem_ack;
  // The ACK_TIMEOUT-th ACCESS cycle without ack ends the access.
  assign timeout  = (state_q == StAccess) & ~mem_ack & (cnt_q == LastCnt);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StAccess;
      StAccess: if (ack_hit || timeout) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    StallM  = 1'b0;
    mem_req = 1'b0;
    unique case (state_q)
      StIdle:   StallM = start;
      StAccess: begin
        StallM  = 1'b1;
        mem_req = 1'b1;
      end
      default: ;
    endcase
  end

  // Request lane enables and replicated store data
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteDataM;
    if (is_byte) begin
      be_d    = 4'b1000 >> AddrM[1:0];
      wdata_d = {4{WriteDataM[7:0]}};
    end else if (is_half) begin
      be_d    = AddrM[1] ? 4'b0011 : 4'b1100;
      wdata_d = {2{WriteDataM[15:0]}};
    end
  end

  // Load lane select and extension
  always_comb begin
    lane_byte = mem_rdata[7:0];
    unique case (off_q)
      2'd0:    lane_byte = mem_rdata[31:24];
      2'd1:    lane_byte = mem_rdata[23:16];
      2'd2:    lane_byte = mem_rdata[15:8];
      default: lane_byte = mem_rdata[7:0];
    endcase
    lane_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    if (byte_q)      load_ext = {{24{sign_q & lane_byte[7]}}, lane_byte};
    else if (half_q) load_ext = {{16{sign_q & lane_half[15]}}, lane_half};
    else             load_ext = mem_rdata;
  end

  // Request capture, timeout counter and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      we_q     <= 1'b0;
      load_q   <= 1'b0;
      sign_q   <= 1'b0;
      byte_q   <= 1'b0;
      half_q   <= 1'b0;
      off_q    <= 2'b00;
      be_q     <= 4'b0000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      if (start) begin
        cnt_q   <= '0;
        we_q    <= MemWriteM;
        load_q  <= ~MemWriteM;
        sign_q  <= LoadSignM;
        byte_q  <= is_byte;
        half_q  <= is_half;
        off_q   <= AddrM[1:0];
        be_q    <= be_d;
        addr_q  <= {AddrM[31:2], 2'b00};
        wdata_q <= wdata_d;
      end else if (state_q == StAccess) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (ack_hit) begin
        if (load_q) rdata_q <= load_ext;
        rvalid_q <= load_q;
      end else if (timeout) begin
        if (load_q) rdata_q <= '0;
        rvalid_q <= load_q;
        err_q    <= 1'b1;
      end
    end
  end

  assign MisalignM  = misalign;
  assign ReadValidW = rvalid_q;
  assign ReadDataW  = rdata_q;
  assign ErrorM     = err_q;
  assign mem_we     = we_q;
  assign mem_be     = be_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one linear sequence of hand-computed steps.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWriteM, MemToRegM, LoadSignM;
  logic [1:0]  MaskOp;
  logic [31:0] AddrM, WriteDataM;
  logic        StallM, MisalignM, ReadValidW, ErrorM;
  logic [31:0] ReadDataW;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.ACK_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWriteM  (MemWriteM),
    .MemToRegM  (MemToRegM),
    .MaskOp     (MaskOp),
    .LoadSignM  (LoadSignM),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .ReadValidW (ReadValidW),
    .ReadDataW  (ReadDataW),
    .ErrorM     (ErrorM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic rd, input logic [1:0] mask, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    MemWriteM  = we;
    MemToRegM  = rd;
    MaskOp     = mask;
    LoadSignM  = sgn;
    AddrM      = addr;
    WriteDataM = wdata;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();
    step();
    check("rst_stall", {31'b0, StallM}, 32'd0);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_rvalid", {31'b0, ReadValidW}, 32'd0);
    check("rst_err", {31'b0, ErrorM}, 32'd0);
    check("rst_rdata", ReadDataW, 32'h0);
    check("rst_be", {28'b0, mem_be}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    rst = 1'b1;
    step();

    // LW 0x100, ack on first ACCESS cycle (held high from the accept cycle, ignored in IDLE)
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h100, 32'h0);
    check("lw_T_stall", {31'b0, StallM}, 32'd1);
    check("lw_T_req", {31'b0, mem_req}, 32'd0);
    check("lw_T_misalign", {31'b0, MisalignM}, 32'd0);
    step();
    check("lw_T1_req", {31'b0, mem_req}, 32'd1);
    check("lw_T1_stall", {31'b0, StallM}, 32'd1);
    check("lw_be", {28'b0, mem_be}, 32'hF);
    check("lw_addr", mem_addr, 32'h100);
    check("lw_we", {31'b0, mem_we}, 32'd0);
    step();
    check("lw_T2_stall", {31'b0, StallM}, 32'd0);
    check("lw_T2_req", {31'b0, mem_req}, 32'd0);
    check("lw_rvalid", {31'b0, ReadValidW}, 32'd1);
    check("lw_rdata", ReadDataW, 32'hDEADBEEF);
    mem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();
    check("lw_pulse_end", {31'b0, ReadValidW}, 32'd0);
    check("lw_rdata_hold", ReadDataW, 32'hDEADBEEF);

    // LB signed 0x103 -> lane [7:0]
    mem_rdata = 32'h000000F0;
    drive(1'b0, 1'b1, 2'b01, 1'b1, 32'h103, 32'h0);
    step();
    check("lb_be", {28'b0, mem_be}, 32'h1);
    check("lb_addr", mem_addr, 32'h100);
    mem_ack = 1'b1;
    step();
    check("lb_rvalid", {31'b0, ReadValidW}, 32'd1);
    check("lb_rdata", ReadDataW, 32'hFFFFFFF0);
    mem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();

    // LBU same stimulus
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h103, 32'h0);
    step();
    mem_ack = 1'b1;
    step();
    check("lbu_rvalid", {31'b0, ReadValidW}, 32'd1);
    check("lbu_rdata", ReadDataW, 32'h000000F0);
    mem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();

    // LH signed 0x100 -> upper half 0x8001
    mem_rdata = 32'h80011234;
    drive(1'b0, 1'b1, 2'b10, 1'b1, 32'h100, 32'h0);
    step();
    check("lh_be", {28'b0, mem_be}, 32'hC);
    mem_ack = 1'b1;
    step();
    check("lh_rdata", ReadDataW, 32'hFFFF8001);
    mem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();

    // SH 0x202
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h202, 32'h1234ABCD);
    check("sh_T_stall", {31'b0, StallM}, 32'd1);
    step();
    check("sh_req", {31'b0, mem_req}, 32'd1);
    check("sh_be", {28'b0, mem_be}, 32'h3);
    check("sh_wdata", mem_wdata, 32'hABCDABCD);
    check("sh_addr", mem_addr, 32'h200);
    check("sh_we", {31'b0, mem_we}, 32'd1);
    mem_ack = 1'b1;
    step();
    check("sh_rvalid", {31'b0, ReadValidW}, 32'd0);
    check("sh_err", {31'b0, ErrorM}, 32'd0);
    check("sh_stall", {31'b0, StallM}, 32'd0);
    check("sh_rdata_hold", ReadDataW, 32'hFFFF8001);
    mem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();

    // Store and load both high at 0x201: treated as byte store
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h201, 32'h000000A5);
    step();
    check("sb_be", {28'b0, mem_be}, 32'h4);
    check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    check("sb_we", {31'b0, mem_we}, 32'd1);
    mem_ack = 1'b1;
    step();
    check("sb_rvalid", {31'b0, ReadValidW}, 32'd0);
    mem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();

    // Misaligned LW 0x101 with a stray ack: no request, no stall
    mem_ack = 1'b1;
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0);
    check("mis_flag", {31'b0, MisalignM}, 32'd1);
    check("mis_stall", {31'b0, StallM}, 32'd0);
    step();
    check("mis_req1", {31'b0, mem_req}, 32'd0);
    step();
    check("mis_req2", {31'b0, mem_req}, 32'd0);
    check("mis_rvalid", {31'b0, ReadValidW}, 32'd0);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h203, 32'h0);
    check("mis_half", {31'b0, MisalignM}, 32'd1);
    check("mis_half_stall", {31'b0, StallM}, 32'd0);
    mem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("mis_idle", {31'b0, MisalignM}, 32'd0);
    step();

    // Reset during third ACCESS cycle
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h400, 32'h0);
    step();
    step();
    step();
    check("rstmid_req", {31'b0, mem_req}, 32'd1);
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();
    check("rstmid_req_drop", {31'b0, mem_req}, 32'd0);
    check("rstmid_stall", {31'b0, StallM}, 32'd0);
    check("rstmid_rvalid", {31'b0, ReadValidW}, 32'd0);
    check("rstmid_err", {31'b0, ErrorM}, 32'd0);
    check("rstmid_rdata", ReadDataW, 32'h0);
    rst = 1'b1;
    step();
    check("rstmid_rvalid2", {31'b0, ReadValidW}, 32'd0);
    check("rstmid_err2", {31'b0, ErrorM}, 32'd0);

    // LW 0x500 to leave non-zero data ahead of the timeout
    mem_rdata = 32'hCAFEF00D;
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h500, 32'h0);
    step();
    mem_ack = 1'b1;
    step();
    check("lw2_rdata", ReadDataW, 32'hCAFEF00D);
    mem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();

    // Timeout: 16 ACCESS cycles without ack
    mem_rdata = 32'h55555555;
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h300, 32'h0);
    step();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to_req_c%0d", i + 1), {31'b0, mem_req}, 32'd1);
      check($sformatf("to_stall_c%0d", i + 1), {31'b0, StallM}, 32'd1);
      step();
    end
    check("to_req_drop", {31'b0, mem_req}, 32'd0);
    check("to_err", {31'b0, ErrorM}, 32'd1);
    check("to_stall", {31'b0, StallM}, 32'd0);
    check("to_rdata", ReadDataW, 32'h0);
    check("to_rvalid", {31'b0, ReadValidW}, 32'd1);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();
    check("to_err_end", {31'b0, ErrorM}, 32'd0);
    check("to_idle_req", {31'b0, mem_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum ACCESS cycles allowed without mem_ack before abort.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port MemWriteM  input  1  store request from M stage.
REQ-005 SHALL have port MemToRegM  input  1  load request from M stage.
REQ-006 SHALL have port MaskOp  input  2  access size: 00 word, 01 byte, 10 halfword, 11 treated as word.
REQ-007 SHALL have port LoadSignM  input  1  1 = sign-extend, 0 = zero-extend sub-word loads.
REQ-008 SHALL have port AddrM  input  32  byte address.
REQ-009 SHALL have port WriteDataM  input  32  store data, right-justified.
REQ-010 SHALL have port StallM  output  1  freezes the pipeline while an access is outstanding.
REQ-011 SHALL have port MisalignM  output  1  combinational misaligned-access flag.
REQ-012 SHALL have port ReadValidW  output  1  one-cycle pulse: ReadDataW valid.
REQ-013 SHALL have port ReadDataW  output  32  extended load result.
REQ-014 SHALL have port ErrorM  output  1  one-cycle pulse on timeout.
REQ-015 SHALL have ports mem_req out 1, mem_we out 1, mem_be out 4, mem_addr out 32, mem_wdata out 32, mem_ack in 1, mem_rdata in 32, forming the memory-side request/ack interface.

Function
REQ-016 SHALL define an access as MemWriteM|MemToRegM; when both are high, the access SHALL be a store.
REQ-017 SHALL flag MisalignM=1 for word with AddrM[1:0]!=0 or halfword with AddrM[0]!=0; misaligned accesses SHALL issue no memory request and SHALL NOT stall.
REQ-018 SHALL implement FSM IDLE, ACCESS, RESP; IDLE -> ACCESS on an aligned access, ACCESS -> RESP on mem_ack or timeout, RESP -> IDLE unconditionally.
REQ-019 SHALL assert StallM combinationally in IDLE when an aligned access is present, and throughout ACCESS; StallM SHALL be 0 in RESP.
REQ-020 SHALL ignore MemWriteM/MemToRegM in RESP and ACCESS (the request is held by the stalled pipeline and captured once).
REQ-021 SHALL register mem_addr={AddrM[31:2],2'b00}, mem_we, mem_be and mem_wdata on the IDLE->ACCESS edge and hold them stable with mem_req=1 for all of ACCESS.
REQ-022 SHALL use big-endian lanes: byte mem_be=4'b1000>>AddrM[1:0]; halfword mem_be=1100 (AddrM[1]=0) or 0011; word 1111.
REQ-023 SHALL replicate store data: byte {4{WriteDataM[7:0]}}, halfword {2{WriteDataM[15:0]}}, word unchanged.
REQ-024 SHALL capture mem_rdata on the cycle mem_ack is sampled in ACCESS, select the addressed lane and extend it per the registered LoadSignM into ReadDataW.
REQ-025 SHALL pulse ReadValidW=1 in RESP for loads only; ReadDataW SHALL hold its value until the next load completes.
REQ-026 SHALL give minimum latency: accept at T, mem_req at T+1, ack at T+1, RESP at T+2 (two stall cycles).
REQ-027 SHALL count ACCESS cycles; if ACK_TIMEOUT cycles elapse without mem_ack, SHALL drop mem_req, enter RESP, pulse ErrorM, and force ReadDataW=0 with ReadValidW=1 for loads.
REQ-028 SHALL ignore mem_ack outside ACCESS.

Reset
REQ-029 SHALL, on rst=0 at a clock edge, enter IDLE and clear mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadDataW, ReadValidW, ErrorM and the timeout counter.
REQ-030 SHALL, on reset mid-ACCESS, drop mem_req at that edge and SHALL NOT produce ReadValidW or ErrorM for the aborted access.

Verification
REQ-031 SHALL verify LW at 0x100 with ack on first ACCESS cycle, mem_rdata=0xDEADBEEF -> mem_be=1111, two stall cycles, ReadDataW=0xDEADBEEF, ReadValidW pulse.
REQ-032 SHALL verify LB signed at 0x103 with mem_rdata=0x000000F0 -> mem_be=0001, ReadDataW=0xFFFFFFF0; LBU with same stimulus -> 0x000000F0.
REQ-033 SHALL verify SH at 0x202 with WriteDataM=0x1234ABCD -> mem_be=0011, mem_wdata=0xABCDABCD, mem_addr=0x200, mem_we=1, no ReadValidW.
REQ-034 SHALL verify LW at 0x101 -> MisalignM=1, StallM=0, mem_req never asserted.
REQ-035 SHALL verify no mem_ack for 16 cycles -> mem_req drops, ErrorM pulse, StallM released, ReadDataW=0.
REQ-036 SHALL verify rst=0 during the third ACCESS cycle -> next cycle IDLE, mem_req=0, no ReadValidW, no ErrorM.
